// File: rtl/wb_unit.sv
// wb_unit: write-back stage of the non-pipelined 16-bit core.
// Takes a retiring instruction's destination and result source, and selects
// the write data from the ALU, the immediate, the link value or a memory load.
// Loads wait for mem_rvalid (bounded by MEM_TIMEOUT) and are byte-extracted.
// Every register-file write is a registered one-cycle rf_we pulse. r0 is never
// written.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   wb_valid/ready    instruction handshake (ready only while idle)
//   wb_rd, wb_sel     destination register and result source
//   wb_ld_mode        load extraction mode
//   alu_result, imm_data, link_data   non-load sources
//   mem_rvalid/rdata  load response
//   rf_we/waddr/wdata register-file write port (registered)
//   wb_busy           waiting on memory
//   wb_err            one-cycle pulse when a load times out
// Optional (macro WB_BYPASS_EN):
//   rs1_addr/rs2_addr, rs1_rdata/rs2_rdata in; rs1_fwd/rs2_fwd out
//   These forward the same-cycle register-file write to decode.
module wb_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [1:0]        wb_sel,
    input  logic [1:0]        wb_ld_mode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] imm_data,
    input  logic [DATA_W-1:0] link_data,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_busy,
    output logic              wb_err
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rs1_rdata,
    input  logic [DATA_W-1:0] rs2_rdata,
    output logic [DATA_W-1:0] rs1_fwd,
    output logic [DATA_W-1:0] rs2_fwd
`endif
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] ld_rd, ld_rd_nxt;
    logic [1:0]        ld_mode, ld_mode_nxt;
    logic              we_nxt, err_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [DATA_W-1:0] ld_data;

    assign wb_ready = (state == IDLE);
    assign wb_busy  = (state == WAIT_MEM);

    always_comb begin
        ld_data = mem_rdata;
        unique case (ld_mode)
            2'b00: ld_data = mem_rdata;
            2'b01: ld_data = {{(DATA_W-8){mem_rdata[7]}}, mem_rdata[7:0]};
            2'b10: ld_data = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
            2'b11: ld_data = {{(DATA_W-8){mem_rdata[15]}}, mem_rdata[15:8]};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ld_rd_nxt   = ld_rd;
        ld_mode_nxt = ld_mode;
        we_nxt      = 1'b0;
        err_nxt     = 1'b0;
        waddr_nxt   = rf_waddr;
        wdata_nxt   = rf_wdata;
        unique case (state)
            IDLE: begin
                if (wb_valid) begin
                    if (wb_sel == 2'b01) begin
                        ld_rd_nxt   = wb_rd;
                        ld_mode_nxt = wb_ld_mode;
                        cnt_nxt     = '0;
                        state_nxt   = WAIT_MEM;
                    end else begin
                        we_nxt    = (wb_rd != '0);
                        waddr_nxt = wb_rd;
                        unique case (wb_sel)
                            2'b10:   wdata_nxt = imm_data;
                            2'b11:   wdata_nxt = link_data;
                            default: wdata_nxt = alu_result;
                        endcase
                    end
                end
            end
            WAIT_MEM: begin
                // Data arriving in the timeout cycle still wins over the abort.
                if (mem_rvalid) begin
                    we_nxt    = (ld_rd != '0);
                    waddr_nxt = ld_rd;
                    wdata_nxt = ld_data;
                    state_nxt = IDLE;
                end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ld_rd    <= '0;
            ld_mode  <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ld_rd    <= ld_rd_nxt;
            ld_mode  <= ld_mode_nxt;
            rf_we    <= we_nxt;
            rf_waddr <= waddr_nxt;
            rf_wdata <= wdata_nxt;
            wb_err   <= err_nxt;
        end
    end

`ifdef WB_BYPASS_EN
    assign rs1_fwd = (rf_we && rf_waddr == rs1_addr) ? rf_wdata : rs1_rdata;
    assign rs2_fwd = (rf_we && rf_waddr == rs2_addr) ? rf_wdata : rs2_rdata;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Testbench for wb_unit: directed scenarios followed by random transactions.
// Each transaction's outcome is predicted from its own inputs (source value,
// extraction of the load word, response delay vs. timeout limit).
module tb_wb_unit;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_rd;
    logic [1:0]    wb_sel;
    logic [1:0]    wb_ld_mode;
    logic [DW-1:0] alu_result, imm_data, link_data;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          wb_busy;
    logic          wb_err;
`ifdef WB_BYPASS_EN
    logic [AW-1:0] rs1_addr, rs2_addr;
    logic [DW-1:0] rs1_rdata, rs2_rdata, rs1_fwd, rs2_fwd;
`endif

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data;
    bit            hold_rs = 1'b0;

    always #5 clk = ~clk;

    wb_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_sel(wb_sel), .wb_ld_mode(wb_ld_mode),
        .alu_result(alu_result), .imm_data(imm_data), .link_data(link_data),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_busy(wb_busy), .wb_err(wb_err)
`ifdef WB_BYPASS_EN
        , .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] extract(input logic [1:0] mode, input logic [DW-1:0] w);
        int unsigned lo, hi;
        lo = w % 256;
        hi = w / 256;
        case (mode)
            2'b00:   return w;
            2'b01:   return DW'((lo >= 128) ? lo + 32'hFF00 : lo);
            2'b10:   return DW'(lo);
            default: return DW'((hi >= 128) ? hi + 32'hFF00 : hi);
        endcase
    endfunction

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] a,
                                           input logic [DW-1:0] i, input logic [DW-1:0] l);
        if (sel == 2'b10) return i;
        if (sel == 2'b11) return l;
        return a;
    endfunction

    task automatic drive_misc();
        alu_result = DW'($urandom);
        imm_data   = DW'($urandom);
        link_data  = DW'($urandom);
        mem_rdata  = DW'($urandom);
`ifdef WB_BYPASS_EN
        if (!hold_rs) begin
            rs1_addr  = AW'($urandom);
            rs2_addr  = AW'($urandom);
            rs1_rdata = DW'($urandom);
            rs2_rdata = DW'($urandom);
        end
`endif
    endtask

    // Compare outputs after a clock edge; wrote=1 means a write event happened
    // (including to r0, which updates addr/data but never strobes rf_we).
    task automatic sample(input string tag, input bit wrote, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit exp_err, input bit exp_busy);
        bit exp_we;
        exp_we = wrote && (a != 0);
        if (wrote) begin
            last_addr = a;
            last_data = d;
        end
        check({tag, ".we"},    32'(rf_we),    32'(exp_we));
        check({tag, ".addr"},  32'(rf_waddr), 32'(last_addr));
        check({tag, ".data"},  32'(rf_wdata), 32'(last_data));
        check({tag, ".err"},   32'(wb_err),   32'(exp_err));
        check({tag, ".busy"},  32'(wb_busy),  32'(exp_busy));
        check({tag, ".ready"}, 32'(wb_ready), 32'(!exp_busy));
`ifdef WB_BYPASS_EN
        check({tag, ".fwd1"}, 32'(rs1_fwd),
              32'((exp_we && last_addr == rs1_addr) ? last_data : rs1_rdata));
        check({tag, ".fwd2"}, 32'(rs2_fwd),
              32'((exp_we && last_addr == rs2_addr) ? last_data : rs2_rdata));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wb_valid = 1'b0; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        last_addr = '0;
        last_data = '0;
        sample("reset", 1'b0, '0, '0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic do_idle(input bit rv);
        @(negedge clk);
        drive_misc();
        wb_valid = 1'b0; mem_rvalid = rv;
        @(posedge clk); #1;
        sample("idle", 1'b0, '0, '0, 1'b0, 1'b0);
        mem_rvalid = 1'b0;
    endtask

    task automatic do_nonload(input logic [AW-1:0] rd, input logic [1:0] sel,
                              input logic [DW-1:0] val);
        @(negedge clk);
        drive_misc();
        wb_valid = 1'b1; wb_rd = rd; wb_sel = sel; wb_ld_mode = 2'($urandom);
        alu_result = val; imm_data = val; link_data = val;
        if (sel != 2'b00) alu_result = ~val;
        mem_rvalid = 1'($urandom);
        @(posedge clk); #1;
        sample("nonload", 1'b1, rd, val, 1'b0, 1'b0);
        wb_valid = 1'b0; mem_rvalid = 1'b0;
    endtask

    // delay = cycle in WAIT_MEM (1-based) carrying mem_rvalid; > TO never responds
    task automatic do_load(input logic [AW-1:0] rd, input logic [1:0] mode,
                           input logic [DW-1:0] word, input int unsigned delay);
        @(negedge clk);
        drive_misc();
        wb_valid = 1'b1; wb_rd = rd; wb_sel = 2'b01; wb_ld_mode = mode; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        sample("ld_accept", 1'b0, '0, '0, 1'b0, 1'b1);
        for (int unsigned k = 1; k <= TO; k++) begin
            @(negedge clk);
            drive_misc();
            // Keep offering other instructions; none may be accepted while busy.
            wb_valid = 1'b1; wb_rd = AW'($urandom); wb_sel = 2'($urandom);
            wb_ld_mode = 2'($urandom);
            mem_rvalid = (k == delay);
            if (k == delay) mem_rdata = word;
            @(posedge clk); #1;
            if (k == delay) begin
                sample("ld_data", 1'b1, rd, extract(mode, word), 1'b0, 1'b0);
                break;
            end else if (k == TO) begin
                sample("ld_timeout", 1'b0, '0, '0, 1'b1, 1'b0);
            end else begin
                sample("ld_wait", 1'b0, '0, '0, 1'b0, 1'b1);
            end
        end
        wb_valid = 1'b0; mem_rvalid = 1'b0;
        do_idle(1'b0);
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; mem_rvalid = 1'b0;
        wb_rd = '0; wb_sel = '0; wb_ld_mode = '0;
        last_addr = '0; last_data = '0;
        drive_misc();
        do_reset();

        // reset in the middle of a load: dropped silently
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 4'd3; wb_sel = 2'b01; wb_ld_mode = 2'b00;
        @(posedge clk); #1;
        sample("midld_acc", 1'b0, '0, '0, 1'b0, 1'b1);
        wb_valid = 1'b0;
        do_reset();
        do_idle(1'b0);

        // back-to-back non-loads
        do_nonload(4'd1, 2'b00, 16'h1234);
        do_nonload(4'd2, 2'b10, 16'hFF80);
        do_nonload(4'd7, 2'b11, 16'h0042);
        do_idle(1'b1);

        // load modes
        do_load(4'd9, 2'b00, 16'hA5C3, 2);
        do_load(4'd9, 2'b01, 16'hA5C3, 1);
        do_load(4'd9, 2'b10, 16'hA5C3, 3);
        do_load(4'd9, 2'b11, 16'hA5C3, 5);

        // timeout, then data exactly in the timeout cycle
        do_load(4'd4, 2'b00, 16'h1111, TO + 1);
        do_load(4'd4, 2'b00, 16'h2222, TO);

        // r0 suppression
        do_nonload(4'd0, 2'b00, 16'hBEEF);
        do_load(4'd0, 2'b00, 16'h7777, 2);
        do_load(4'd0, 2'b00, 16'h7777, TO + 2);

`ifdef WB_BYPASS_EN
        hold_rs = 1'b1;
        rs1_addr = 4'd5; rs1_rdata = 16'h0000; rs2_addr = 4'd6; rs2_rdata = 16'h3C3C;
        do_nonload(4'd5, 2'b00, 16'h5555);
        do_idle(1'b0);
        hold_rs = 1'b0;
`endif

        // random mix
        for (int i = 0; i < 60; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                do_idle(1'($urandom));
            end else if (kind == 1) begin
                do_load(AW'($urandom), 2'($urandom), DW'($urandom), $urandom_range(1, TO + 3));
            end else begin
                logic [1:0] s;
                s = 2'($urandom_range(0, 2));
                if (s == 2'b01) s = 2'b11;
                do_nonload(AW'($urandom), s, DW'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
